// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH bits split into NSTAGE slices
// of GROUP-bit lookahead groups, with a registered carry between slices.
module pipe_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int NSTAGE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / NSTAGE;
  localparam int NG = SW / GROUP;

  // One slice: per-group generate/propagate, group carries by full lookahead
  // from the slice carry-in, then bit carries rippled inside each group.
  function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic ci);
    logic [SW-1:0] g, p, s;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic          c, t;
    g = x & y;
    p = x ^ y;
    s = '0;
    for (int j = 0; j < NG; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
        gp[j] = gp[j] & p[j*GROUP+i];
      end
    end
    gc[0] = ci;
    for (int j = 0; j < NG; j++) begin
      c = 1'b0;
      for (int i = 0; i <= j; i++) begin
        t = gg[i];
        for (int m = i + 1; m <= j; m++) t = t & gp[m];
        c = c | t;
      end
      t = ci;
      for (int m = 0; m <= j; m++) t = t & gp[m];
      gc[j+1] = c | t;
    end
    for (int j = 0; j < NG; j++) begin
      c = gc[j];
      for (int i = 0; i < GROUP; i++) begin
        s[j*GROUP+i] = p[j*GROUP+i] ^ c;
        c = g[j*GROUP+i] | (p[j*GROUP+i] & c);
      end
    end
    return {gc[NG], s};
  endfunction

  logic [NSTAGE-1:0]            v, ld, pv;
  logic [NSTAGE-1:0][WIDTH-1:0] ra, reb, rs;
  logic [NSTAGE-1:0][WIDTH-1:0] pa, peb, ps, ns;
  logic [NSTAGE-1:0]            rc, rz, pc, pz, nc, nz;
  logic                         ovf_q, last_ovf, full;
  logic [SW:0]                  r;
  logic                         unused_stage_bits;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Stage k loads when it is empty or everything downstream of it will move,
  // so in_ready depends only on out_ready and the stage valid bits.
  always_comb begin
    ld   = '0;
    full = 1'b1;
    for (int k = 0; k < NSTAGE; k++) begin
      full = 1'b1;
      for (int m = k; m < NSTAGE; m++) full = full & v[m];
      ld[k] = out_ready | ~full;
    end
  end

  assign in_ready = ld[0];

  always_comb begin
    pv  = '0; pa = '0; peb = '0; ps = '0; pc = '0; pz = '0;
    ns  = '0; nc = '0; nz = '0; r = '0;
    pv[0]  = in_valid;
    pa[0]  = a;
    peb[0] = op ? ~b : b;
    ps[0]  = '0;
    pc[0]  = op ? ~cin : cin;
    pz[0]  = 1'b1;
    for (int k = 1; k < NSTAGE; k++) begin
      pv[k]  = v[k-1];
      pa[k]  = ra[k-1];
      peb[k] = reb[k-1];
      ps[k]  = rs[k-1];
      pc[k]  = rc[k-1];
      pz[k]  = rz[k-1];
    end
    for (int k = 0; k < NSTAGE; k++) begin
      r = cla_slice(pa[k][k*SW +: SW], peb[k][k*SW +: SW], pc[k]);
      ns[k] = ps[k];
      ns[k][k*SW +: SW] = r[SW-1:0];
      nc[k] = r[SW];
      nz[k] = pz[k] & ~|r[SW-1:0];
    end
    last_ovf = (pa[NSTAGE-1][WIDTH-1] == peb[NSTAGE-1][WIDTH-1]) &&
               (ns[NSTAGE-1][WIDTH-1] != pa[NSTAGE-1][WIDTH-1]);
  end

  // Data registers only move with a valid op, so outputs hold across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v     <= '0;
      ra    <= '0;
      reb   <= '0;
      rs    <= '0;
      rc    <= '0;
      rz    <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (ld[k]) begin
          v[k] <= pv[k];
          if (pv[k]) begin
            ra[k]  <= pa[k];
            reb[k] <= peb[k];
            rs[k]  <= ns[k];
            rc[k]  <= nc[k];
            rz[k]  <= nz[k];
          end
        end
      end
      if (ld[NSTAGE-1] && pv[NSTAGE-1]) ovf_q <= last_ovf;
    end
  end

  // Already-consumed operand bits are dead in later stages and trim away.
  assign unused_stage_bits = ^{ra, reb};

  assign out_valid = v[NSTAGE-1];
  assign sum       = rs[NSTAGE-1];
  assign cout      = rc[NSTAGE-1];
  assign zero      = rz[NSTAGE-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Directed bench for pipe_cla_addsub (WIDTH=32, GROUP=4, NSTAGE=4): hand-computed
// vectors, throughput, backpressure and mid-flight reset, with an expected queue.
module tb_pipe_cla_addsub;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, cin, op, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cout, ovf, zero;

  int n_cmp = 0;
  int n_err = 0;
  logic [W+2:0] exp_q[$];   // {ovf, zero, cout, sum}

  pipe_cla_addsub #(.WIDTH(W), .GROUP(4), .NSTAGE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic o);
    logic [W-1:0] e;
    logic [W:0]   f;
    logic         ov;
    e  = o ? ~y : y;
    f  = {1'b0, x} + {1'b0, e} + {{W{1'b0}}, (o ? ~ci : ci)};
    ov = (x[W-1] == e[W-1]) && (f[W-1] != x[W-1]);
    return {ov, (f[W-1:0] == '0), f[W], f[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // scoreboard: input side pushes the reference result, output side pops and compares
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(a, b, cin, op));
  end

  always @(negedge clk) begin
    logic [W+2:0] e;
    if (out_valid && out_ready) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL out_unexpected: observed queue size %0d expected >0", exp_q.size());
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_sum", sum, e[W-1:0]);
        check1("sb_cout", cout, e[W]);
        check1("sb_zero", zero, e[W+1]);
        check1("sb_ovf", ovf, e[W+2]);
      end
    end
  end

  // driver tasks
  task automatic set_rand_op();
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom_range(0, 1));
    op  = 1'($urandom_range(0, 1));
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic o, input logic [W-1:0] es,
                         input logic ecout, input logic eovf, input logic ezero);
    int n;
    @(posedge clk); #1;
    a = x; b = y; cin = ci; op = o; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 32'd4);
    check({tag, "_sum"}, sum, es);
    check1({tag, "_cout"}, cout, ecout);
    check1({tag, "_ovf"}, ovf, eovf);
    check1({tag, "_zero"}, zero, ezero);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    logic [W-1:0] held;
    logic held_set;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = 1'b0;

    // reset state
    @(negedge clk);
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 32'h0);
    check1("rst_cout", cout, 1'b0);
    check1("rst_ovf", ovf, 1'b0);
    check1("rst_zero", zero, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    check1("post_rst_in_ready", in_ready, 1'b1);

    // directed arithmetic
    run_one("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("sub_ovf",  32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_one("add_ovf",  32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("sub_bin",  32'h5, 32'h3, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    run_one("sub_neg",  32'h3, 32'h5, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("add_cin_slices", 32'h00FF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
    run_one("sub_self", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    check("directed_drained", exp_q.size(), 32'd0);

    // throughput: 8 back-to-back ops
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_rand_op();
      in_valid = 1'b1;
      @(negedge clk);
      check1("tp_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check1("tp_out_valid_7", out_valid, 1'b1);
    #1;
    check("tp_pending_one", exp_q.size(), 32'd1);
    @(negedge clk);
    check1("tp_out_valid_8", out_valid, 1'b1);
    #1;
    check("tp_drained", exp_q.size(), 32'd0);

    // backpressure: fill with out_ready low
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc = 0;
    held = '0;
    held_set = 1'b0;
    set_rand_op();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (!held_set) begin
          held = sum;
          held_set = 1'b1;
        end else begin
          check("bp_hold_sum", sum, held);
        end
      end
      if (in_ready) acc++;
      @(posedge clk); #1;
      if (in_ready) set_rand_op();
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 32'd4);
    @(negedge clk);
    check1("bp_full_in_ready", in_ready, 1'b0);
    check1("bp_out_valid", out_valid, 1'b1);
    check("bp_hold_final", sum, held);
    check("bp_queued", exp_q.size(), 32'd4);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("bp_drain_valid", out_valid, 1'b1);
    end
    #1;
    check("bp_drained", exp_q.size(), 32'd0);
    @(negedge clk);
    check1("bp_empty_after", out_valid, 1'b0);

    // reset with three ops in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rand_op();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    check1("rm_pre_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("rm_out_valid", out_valid, 1'b0);
    check("rm_sum", sum, 32'h0);
    check1("rm_cout", cout, 1'b0);
    check1("rm_ovf", ovf, 1'b0);
    check1("rm_zero", zero, 1'b0);
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    check1("rm_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check1("rm_no_stale", out_valid, 1'b0);
    end
    run_one("rm_new_op", 32'h2, 32'h2, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    check("final_drained", exp_q.size(), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_cla_addsub.md
Name: pipe_cla_addsub

Overview:
- Parameterised, pipelined carry-lookahead adder/subtractor for the multiplier datapath and the ALU.
- Splits a WIDTH-bit operation into NSTAGE register-separated slices.
- Each slice is built from GROUP-bit lookahead groups. The inter-slice carry is registered.
- Valid/ready handshakes on input and output give 1 op/cycle throughput, NSTAGE-cycle latency and lossless backpressure.

Parameters:
- WIDTH, 32, operand/result width. Must be divisible by GROUP*NSTAGE.
- GROUP, 4, bits per lookahead group. Generate/propagate are computed per group; group carries are computed by lookahead across the groups of one slice.
- NSTAGE, 4, number of pipeline stages (1..8). Slice width SW = WIDTH/NSTAGE.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- op  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB (sub: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset: every stage valid bit = 0; sum = 0, cout = 0, ovf = 0, zero = 0, out_valid = 0. in_ready = 1 once reset is released.
- Reset is asynchronous. Asserting it mid-operation discards all in-flight ops, with no partial outputs after release.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Arithmetic:
  - Effective B: eb = op ? ~b : b.
  - Effective carry-in: ec = op ? ~cin : cin.
  - Result: {cout, sum} = a + eb + ec, i.e. add gives a+b+cin and sub gives a-b-cin.
  - ovf = (a[W-1] == eb[W-1]) && (sum[W-1] != a[W-1]).
  - zero = ~|sum.
- Pipeline structure:
  - Stage k (0..NSTAGE-1) computes bits [k*SW +: SW] from the registered carry out of stage k-1; stage 0 uses ec.
  - Unprocessed upper operand bits and already-computed lower sum bits travel with the op in stage registers.
  - A partial zero flag (AND of slice-zero results) and the MSB of a and eb are carried forward.
  - ovf and zero are formed in the last stage. Outputs are driven directly from the last stage's registers.
- Stall rule, per-stage bubble-collapsing:
  - Stage k may load when it is empty or when stage k+1 will load this cycle.
  - The last stage may load when it is empty or out_ready = 1.
  - in_ready = stage-0 load enable. It is combinational from out_ready and the valid bits, with no dependency on in_valid.
- Latency: an op accepted in cycle t has out_valid = 1 in cycle t+NSTAGE if no stall occurs. Throughput is 1 op/cycle with out_ready held high.
- Capacity: NSTAGE ops in flight. When all stages are full and out_ready = 0, in_ready = 0.
- Stability: while out_valid && !out_ready, sum/cout/ovf/zero must not change.
- Simultaneous events: when full with out_ready = 1 and in_valid = 1, accept and emit in the same cycle; occupancy is unchanged.
- Empty pipeline with in_valid = 0: nothing changes and out_valid stays 0.
- Ordering is strictly FIFO. There is no drop or duplication under any stall pattern.
- Data outputs hold their last value when out_valid = 0; the consumer must ignore them.
- Wrap-around: the carry out of the MSB goes only to cout and never feeds back.

Test Plan (WIDTH=32, GROUP=4, NSTAGE=4, latency 4):
- Add carry wrap: a=0xFFFFFFFF, b=0x00000001, cin=0, op=0, out_ready=1 -> 4 cycles later sum=0x00000000, cout=1, ovf=0, zero=1.
- Sub overflow: a=0x80000000, b=0x00000001, cin=0, op=1 -> sum=0x7FFFFFFF, cout=1, ovf=1, zero=0.
- Add signed overflow and borrow-in: a=0x7FFFFFFF, b=0x1, cin=0, op=0 -> sum=0x80000000, cout=0, ovf=1. Separately, a=5, b=3, cin=1, op=1 -> sum=0x00000001, cout=1.
- Throughput: 8 back-to-back random ops with out_ready=1 -> results in order on consecutive cycles 4..11 and match the reference model; in_ready stays 1.
- Backpressure: in_valid=1 continuously and out_ready=0 for 8 cycles -> exactly 4 ops accepted, then in_ready=0. out_valid=1 with sum held constant. On out_ready=1, results drain in order, one per cycle, with no loss or duplicate.
- Reset mid-flight: 3 ops in flight, pulse rst_n low for 1 cycle asynchronously between edges -> out_valid drops to 0 immediately and all outputs are 0. After release, in_ready=1 and no stale result appears; a new op a=2, b=2, op=0 yields sum=4 after 4 cycles.
